// File: rtl/lpc_capture_pkg.sv
// Shared constants, FSM state type and byte-0 packing for the LPC capture controller.
// LPC_CAPTURE_TIMESTAMP_EN selects the 11-byte timestamped record layout.
package lpc_capture_pkg;

  localparam int unsigned REC_BYTES_BASE = 9;
  localparam int unsigned REC_BYTES_TS   = 11;
`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int unsigned REC_BYTES = REC_BYTES_TS;
`else
  localparam int unsigned REC_BYTES = REC_BYTES_BASE;
`endif
  localparam int unsigned REC_W = REC_BYTES * 8;

  localparam int unsigned B0_CTDIR_W = 4;
  localparam int unsigned B0_SIZE_W  = 3;
  localparam logic        B0_PAD     = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_e;

  function automatic logic [7:0] pack_b0(input logic [B0_CTDIR_W-1:0] ctdir,
                                         input logic [B0_SIZE_W-1:0] size);
    return {ctdir, B0_PAD, size};
  endfunction

endpackage

// File: rtl/lpc_capture_ctrl_if.sv
// Byte-stream handshake between the capture serializer (master) and its sink (slave).
interface lpc_capture_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lpc_rec_fifo.sv
// Synchronous first-word-fall-through record FIFO; DEPTH must be a power of two (2..16).
module lpc_rec_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             lpc_clock,
  input  logic             lpc_reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [4:0]       level_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (level_r == 5'(DEPTH));
  assign empty   = (level_r == 5'd0);
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];
  // Fullness is judged on the pre-edge level, so a same-cycle pop never frees a slot early.
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;

  // Storage array write port.
  always_ff @(posedge lpc_clock) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 5'd0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   level_r <= level_r + 5'd1;
        2'b01:   level_r <= level_r - 5'd1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/lpc_capture_ctrl.sv
// Filters decoded LPC cycles into a record FIFO and streams each record out MSB-first, byte by byte.
// Define LPC_CAPTURE_TIMESTAMP_EN to prepend a 16-bit cycle timestamp after byte 0.
module lpc_capture_ctrl
  import lpc_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                lpc_clock,
  input  logic                lpc_reset,
  input  logic                in_valid,
  input  logic [3:0]          in_cyctype_dir,
  input  logic [31:0]         in_addr,
  input  logic [31:0]         in_data,
  input  logic [2:0]          in_data_size,
  input  logic                cfg_enable,
  input  logic [15:0]         cfg_ctdir_mask,
  lpc_capture_ctrl_if.master  tx,
  output logic [4:0]          fifo_level,
  output logic [7:0]          overflow_count
);

  localparam logic [3:0] LAST_BYTE = 4'(REC_BYTES - 1);

  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             adv_s;
  logic             last_s;
  logic             full_s;
  logic             empty_s;
  logic [REC_W-1:0] wr_rec_s;
  logic [REC_W-1:0] rd_rec_s;
  logic [REC_W-1:0] shreg_r;
  logic [3:0]       byte_cnt_r;
  logic             tx_valid_r;
  logic [7:0]       overflow_r;
  ser_state_e       state_r;
  ser_state_e       state_nx;

  assign accept_s = in_valid & cfg_enable & cfg_ctdir_mask[in_cyctype_dir];
  assign push_s   = accept_s & ~full_s;
  assign adv_s    = tx_valid_r & tx.tx_ready;
  assign last_s   = (byte_cnt_r == LAST_BYTE);

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_r;

  // Free-running cycle counter sampled into each pushed record.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      ts_r <= 16'd0;
    end else begin
      ts_r <= ts_r + 16'd1;
    end
  end

  assign wr_rec_s = {pack_b0(in_cyctype_dir, in_data_size), ts_r, in_addr, in_data};
`else
  assign wr_rec_s = {pack_b0(in_cyctype_dir, in_data_size), in_addr, in_data};
`endif

  lpc_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .wr_en     (push_s),
    .wr_data   (wr_rec_s),
    .rd_en     (pop_s),
    .rd_data   (rd_rec_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  // Serializer next-state and pop decode.
  always_comb begin
    state_nx = state_r;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pop_s    = 1'b1;
        state_nx = ST_SEND;
      end
      ST_SEND: begin
        if (adv_s && last_s) begin
          if (empty_s) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_LOAD;
          end
        end else begin
          state_nx = ST_SEND;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Serializer state, shift register and byte counter; tx_valid mirrors the SEND state as a flop.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      state_r    <= ST_IDLE;
      tx_valid_r <= 1'b0;
      shreg_r    <= '0;
      byte_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nx;
      tx_valid_r <= (state_nx == ST_SEND);
      if (pop_s) begin
        shreg_r    <= rd_rec_s;
        byte_cnt_r <= 4'd0;
      end else if (adv_s) begin
        shreg_r    <= {shreg_r[REC_W-9:0], 8'd0};
        byte_cnt_r <= byte_cnt_r + 4'd1;
      end
    end
  end

  // Saturating count of accepted strobes lost to a full FIFO.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      overflow_r <= 8'd0;
    end else if (accept_s && full_s && (overflow_r != 8'hFF)) begin
      overflow_r <= overflow_r + 8'd1;
    end
  end

  assign tx.tx_data     = shreg_r[REC_W-1 -: 8];
  assign tx.tx_valid    = tx_valid_r;
  assign overflow_count = overflow_r;

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Directed, table-driven bench for lpc_capture_ctrl (FIFO_DEPTH=4).
// With LPC_CAPTURE_TIMESTAMP_EN defined it also models the timestamp bytes.
module tb_lpc_capture_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_data_size;
  logic        cfg_enable;
  logic [15:0] cfg_ctdir_mask;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_count;

  lpc_capture_ctrl_if bus ();

  lpc_capture_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .cfg_enable     (cfg_enable),
    .cfg_ctdir_mask (cfg_ctdir_mask),
    .tx             (bus),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count)
  );

  always #5 lpc_clock = ~lpc_clock;

  typedef struct {
    logic [3:0]  ctdir;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] mask;
    logic        en;
    logic        emit;
    logic [7:0]  exp_b0;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int         total = 0;
  int         bad = 0;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [15:0] tb_ts;
  logic [15:0] last_ts;

  always @(posedge lpc_clock) begin
    if (!lpc_reset) tb_ts <= 16'd0;
    else            tb_ts <= tb_ts + 16'd1;
  end
`endif

  // Record every byte that will be handshaken at the coming rising edge.
  always @(negedge lpc_clock) begin
    if (lpc_reset && bus.tx_valid && bus.tx_ready) cap_q.push_back(bus.tx_data);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endfunction

  function automatic void push_rec(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(b0);
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    exp_q.push_back(last_ts[15:8]);
    exp_q.push_back(last_ts[7:0]);
`endif
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
  endfunction

  task automatic strobe(input logic [3:0] ct, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    in_cyctype_dir = ct;
    in_data_size   = sz;
    in_addr        = a;
    in_data        = d;
    in_valid       = 1'b1;
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    last_ts = tb_ts;
`endif
    @(posedge lpc_clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    lpc_reset = 1'b0;
    in_valid  = 1'b0;
    @(posedge lpc_clock); #1;
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_count), 32'd0);
    @(posedge lpc_clock); #1;
    lpc_reset = 1'b1;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int idle = 0;
    int cyc = 0;
    while (idle < 3 && cyc < 2000) begin
      @(posedge lpc_clock); #1;
      cyc++;
      if (fifo_level == 5'd0 && !bus.tx_valid) idle++;
      else idle = 0;
    end
    chk({tag, "_drain_done"}, 32'(idle >= 3), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_byte_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [71:0] hand;
    int          n;

    vecs[0] = '{4'h6, 3'd2, 32'h1234_7FE5, 32'h0000_D569, 16'hFFFF, 1'b1, 1'b1, 8'h62};
    vecs[1] = '{4'h0, 3'd1, 32'h0000_0080, 32'h0000_00A5, 16'hFFFF, 1'b1, 1'b1, 8'h01};
    vecs[2] = '{4'hF, 3'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 16'h8000, 1'b1, 1'b1, 8'hF4};
    vecs[3] = '{4'h3, 3'd4, 32'h0000_1000, 32'h1234_5678, 16'hFFFF, 1'b0, 1'b0, 8'h34};
    vecs[4] = '{4'h2, 3'd1, 32'h0000_0060, 32'h0000_0011, 16'h0040, 1'b1, 1'b0, 8'h21};
    vecs[5] = '{4'h6, 3'd1, 32'hA5A5_0001, 32'h0000_0033, 16'h0040, 1'b1, 1'b1, 8'h61};
    vecs[6] = '{4'h9, 3'd3, 32'h0BAD_F00D, 32'h0102_0304, 16'h0200, 1'b1, 1'b1, 8'h93};

    in_valid = 1'b0; in_cyctype_dir = 4'd0; in_addr = 32'd0; in_data = 32'd0; in_data_size = 3'd0;
    cfg_enable = 1'b1; cfg_ctdir_mask = 16'hFFFF; bus.tx_ready = 1'b1;
    do_reset("rst0");

    // First-byte latency and the hand-computed byte stream of the reference memory write.
    strobe(4'h6, 3'd2, 32'h1234_7FE5, 32'h0000_D569);
    hand = 72'h62_1234_7FE5_0000_D569;
    exp_q.push_back(hand[71:64]);
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    exp_q.push_back(last_ts[15:8]);
    exp_q.push_back(last_ts[7:0]);
`endif
    for (int i = 7; i >= 0; i--) exp_q.push_back(hand[i*8 +: 8]);
    chk("lat_level_after_push", 32'(fifo_level), 32'd1);
    chk("lat_valid_cyc0", 32'(bus.tx_valid), 32'd0);
    @(posedge lpc_clock); #1;
    chk("lat_valid_cyc1", 32'(bus.tx_valid), 32'd0);
    @(posedge lpc_clock); #1;
    chk("lat_valid_cyc2", 32'(bus.tx_valid), 32'd1);
    chk("lat_first_byte", 32'(bus.tx_data), 32'h62);
    drain("ref");
    compare_stream("ref");

    // Table of single strobes across mask/enable/cycle-type combinations.
    for (int v = 0; v < 7; v++) begin
      cfg_enable = vecs[v].en;
      cfg_ctdir_mask = vecs[v].mask;
      strobe(vecs[v].ctdir, vecs[v].size, vecs[v].addr, vecs[v].data);
      if (vecs[v].emit) push_rec(vecs[v].exp_b0, vecs[v].addr, vecs[v].data);
      chk($sformatf("vec%0d_level", v), 32'(fifo_level), 32'(vecs[v].emit));
      drain($sformatf("vec%0d", v));
      compare_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow_count), 32'd0);
    end

    // Mask admits only cycle type 0110.
    cfg_enable = 1'b1; cfg_ctdir_mask = 16'h0040;
    strobe(4'h6, 3'd1, 32'h0000_0100, 32'h0000_00AA);
    push_rec(8'h61, 32'h0000_0100, 32'h0000_00AA);
    strobe(4'h2, 3'd1, 32'h0000_0200, 32'h0000_00BB);
    drain("mask");
    compare_stream("mask");
    chk("mask_overflow", 32'(overflow_count), 32'd0);

    // Back-pressure on the third byte: data must hold, nothing lost or repeated.
    cfg_ctdir_mask = 16'hFFFF; bus.tx_ready = 1'b0;
    strobe(4'h6, 3'd2, 32'h1234_7FE5, 32'h0000_D569);
    push_rec(8'h62, 32'h1234_7FE5, 32'h0000_D569);
    n = 0;
    while (!bus.tx_valid && n < 20) begin @(posedge lpc_clock); #1; n++; end
    chk("stall_valid_up", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1;
    @(posedge lpc_clock); #1;
    @(posedge lpc_clock); #1;
    bus.tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_hold_data%0d", c), 32'(bus.tx_data), 32'(exp_q[2]));
      chk($sformatf("stall_hold_valid%0d", c), 32'(bus.tx_valid), 32'd1);
      @(posedge lpc_clock); #1;
    end
    bus.tx_ready = 1'b1;
    drain("stall");
    compare_stream("stall");

    // Fill with sink blocked: 4 in FIFO, 1 in shift register, 6th dropped, then saturate.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(4'h6, 3'd4, 32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
      if (i < 5) push_rec(8'h64, 32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
      if (i == 2) chk("fill_push_pop_level", 32'(fifo_level), 32'd2);
    end
    chk("fill_level", 32'(fifo_level), 32'd4);
    chk("fill_overflow", 32'(overflow_count), 32'd1);
    chk("fill_shreg_valid", 32'(bus.tx_valid), 32'd1);
    for (int i = 0; i < 260; i++) strobe(4'h6, 3'd4, 32'hEEEE_EEEE, 32'hEEEE_EEEE);
    chk("sat_overflow", 32'(overflow_count), 32'd255);
    chk("sat_level", 32'(fifo_level), 32'd4);
    cfg_enable = 1'b0;
    bus.tx_ready = 1'b1;
    drain("fill");
    compare_stream("fill");

    // Reset in the middle of a record, with another record queued behind it.
    do_reset("rst1");
    cfg_enable = 1'b1;
    strobe(4'h6, 3'd2, 32'hAAAA_0001, 32'h0000_0001);
    strobe(4'h6, 3'd2, 32'hAAAA_0002, 32'h0000_0002);
    n = 0;
    while (cap_q.size() < 4 && n < 50) begin @(posedge lpc_clock); #1; n++; end
    chk("mid_bytes_sent", 32'(cap_q.size()), 32'd4);
    chk("mid_level", 32'(fifo_level), 32'd1);
    do_reset("rst_mid");
    strobe(4'hC, 3'd1, 32'h5555_AAAA, 32'h0000_0077);
    push_rec(8'hC1, 32'h5555_AAAA, 32'h0000_0077);
    drain("post_rst");
    compare_stream("post_rst");

`ifdef LPC_CAPTURE_TIMESTAMP_EN
    // Timestamp value 0x00FF captured on the push edge.
    do_reset("rst_ts");
    n = 0;
    while (tb_ts != 16'h00FF && n < 400) begin @(posedge lpc_clock); #1; n++; end
    strobe(4'h6, 3'd2, 32'h1234_7FE5, 32'h0000_D569);
    push_rec(8'h62, 32'h1234_7FE5, 32'h0000_D569);
    drain("ts");
    chk("ts_byte_count", 32'(cap_q.size()), 32'd11);
    if (cap_q.size() >= 3) begin
      chk("ts_b1", 32'(cap_q[1]), 32'h00);
      chk("ts_b2", 32'(cap_q[2]), 32'hFF);
    end
    compare_stream("ts");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
